// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads one word per PC from instruction memory over
// a valid/ready request channel, waits for the single-cycle response, and
// hands the word plus its PC to decode. Advances the PC once per accepted
// instruction, and handles flush/redirect, bus errors, timeouts and
// misaligned PCs.
module instr_fetch_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        flush,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_fault,
   output logic        pc_en
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   // The counter value seen in the last cycle before the limit is reached;
   // a wait therefore lasts exactly TIMEOUT_CYCLES cycles.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc_reg, pc_next;
   logic        fault_reg, fault_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        drop_reg, drop_next;
   // Set on entry to REQ: pc_in has not been sampled yet for this fetch.
   logic        fresh_reg, fresh_next;

   logic [31:0] pc_aligned;
   logic        pc_mis;
   logic        handshake;
   logic        timeout_hit;

   assign pc_aligned = {pc_in[31:2], 2'b00};
   assign pc_mis     = |pc_in[1:0];

   // On the first REQ cycle the address comes straight from pc_in (which by
   // then already reflects the PC update); afterwards the latched copy keeps
   // the address stable while the request is held.
   assign imem_addr = (state_reg == ST_REQ && fresh_reg) ? pc_aligned : addr_reg;

   // No request while a dropped response is still outstanding, and none at
   // all for a misaligned PC.
   assign imem_req_valid = (state_reg == ST_REQ) && !drop_reg && !(fresh_reg && pc_mis);
   assign handshake      = imem_req_valid && imem_req_ready;
   assign timeout_hit    = (cnt_reg == TIMEOUT_LAST);

   assign if_valid = (state_reg == ST_OUT);
   assign if_instr = instr_reg;
   assign if_pc    = pc_reg;
   assign if_fault = fault_reg;
   // Flush beats acceptance: a flushed instruction never advances the PC.
   assign pc_en    = (state_reg == ST_OUT) && if_ready && !flush;

   // Next-state and datapath decisions; flush overrides the per-state result.
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      instr_next = instr_reg;
      pc_next    = pc_reg;
      fault_next = fault_reg;
      cnt_next   = cnt_reg;
      drop_next  = drop_reg;
      fresh_next = fresh_reg;

      case (state_reg)
         ST_IDLE: begin
            state_next = ST_REQ;
            fresh_next = 1'b1;
            cnt_next   = 8'd0;
         end

         ST_REQ: begin
            if (drop_reg) begin
               // Waiting for the abandoned response; the timeout also
               // releases us in case it never arrives.
               if (imem_rsp_valid || timeout_hit) begin
                  drop_next = 1'b0;
                  cnt_next  = 8'd0;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end else if (fresh_reg && pc_mis) begin
               // Misaligned PC: skip memory and report a fault immediately.
               addr_next  = pc_aligned;
               pc_next    = pc_aligned;
               instr_next = NOP_INSTR;
               fault_next = 1'b1;
               fresh_next = 1'b0;
               state_next = ST_OUT;
            end else begin
               if (fresh_reg) begin
                  addr_next  = pc_aligned;
                  fresh_next = 1'b0;
               end
               if (handshake) begin
                  cnt_next   = 8'd0;
                  state_next = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (imem_rsp_valid) begin
               // A response in the timeout cycle still wins.
               instr_next = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
               fault_next = imem_rsp_err;
               pc_next    = addr_reg;
               state_next = ST_OUT;
            end else if (timeout_hit) begin
               instr_next = NOP_INSTR;
               fault_next = 1'b1;
               pc_next    = addr_reg;
               state_next = ST_OUT;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end

         ST_OUT: begin
            if (if_ready) begin
               state_next = ST_REQ;
               fresh_next = 1'b1;
               cnt_next   = 8'd0;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (flush) begin
         state_next = ST_REQ;
         fresh_next = 1'b1;
         cnt_next   = 8'd0;
         // A request already accepted by memory will still be answered; mark
         // that answer for discard so only one request is ever outstanding.
         if (state_reg == ST_WAIT && !imem_rsp_valid && !timeout_hit)
            drop_next = 1'b1;
         if (state_reg == ST_REQ && handshake)
            drop_next = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         addr_reg  <= 32'd0;
         instr_reg <= 32'd0;
         pc_reg    <= 32'd0;
         fault_reg <= 1'b0;
         cnt_reg   <= 8'd0;
         drop_reg  <= 1'b0;
         fresh_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         instr_reg <= instr_next;
         pc_reg    <= pc_next;
         fault_reg <= fault_next;
         cnt_reg   <= cnt_next;
         drop_reg  <= drop_next;
         fresh_reg <= fresh_next;
      end
   end

endmodule
